// File: rtl/axi_lite_slave_mem_pkg.sv
// Shared types and defaults for the AXI4-Lite slave memory responder.
package axi_lite_pkg;

  localparam int unsigned AXI_ADDR_WIDTH = 32;
  localparam int unsigned AXI_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_RESP
  } rd_state_e;

endpackage

// File: rtl/axi_lite_slave_mem_if.sv
// AXI4-Lite signal bundle; the slave modport is what axi_lite_slave_mem terminates.
interface axi_lite_slave_mem_if #(
  parameter int unsigned ADDR_WIDTH = axi_lite_pkg::AXI_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = axi_lite_pkg::AXI_DATA_WIDTH
);
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;
  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]              S_AXI_AWPROT;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                    S_AXI_WLAST;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;
  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_ARVALID;
  logic                    S_AXI_ARREADY;
  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]              S_AXI_ARPROT;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]              S_AXI_RRESP;
  logic                    S_AXI_RLAST;

  modport slave (
    input  S_AXI_AWVALID, S_AXI_AWADDR, S_AXI_AWPROT,
    input  S_AXI_WVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST,
    input  S_AXI_BREADY,
    input  S_AXI_ARVALID, S_AXI_ARADDR, S_AXI_ARPROT,
    input  S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP,
    output S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST
  );

  modport master (
    output S_AXI_AWVALID, S_AXI_AWADDR, S_AXI_AWPROT,
    output S_AXI_WVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST,
    output S_AXI_BREADY,
    output S_AXI_ARVALID, S_AXI_ARADDR, S_AXI_ARPROT,
    output S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP,
    input  S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST
  );

endinterface

// File: rtl/axi_lite_resp_delay.sv
// Loadable 8-bit down-counter; done_o is high whenever the count has reached zero.
module axi_lite_resp_delay (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [7:0] value_i,
  output logic       done_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite slave with word-addressed backing memory and DECERR on out-of-range access.
// Optional response delay on B/R channels enabled by AXI_SLV_RESP_DELAY_EN.
module axi_lite_slave_mem
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = AXI_DATA_WIDTH,
  parameter int unsigned MEM_DEPTH  = 1024,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned RESP_DELAY = 0
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  axi_lite_slave_mem_if.slave  s_axi
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned SH     = $clog2(STRB_W);
  localparam int unsigned IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] BASE_A  = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic                  aw_full_q, aw_full_d, aw_ok_q, aw_ok_d;
  logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
  logic                  w_full_q, w_full_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  awready_q, awready_d, wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  axi_resp_e             bresp_q, bresp_d;
  rd_state_e             rstate_q, rstate_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  axi_resp_e             rresp_q, rresp_d;

  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [ADDR_WIDTH-1:0] aw_off, ar_off;
  logic                  aw_ok, ar_ok;
  logic                  commit, wload, rload, wdone, rdone;
  logic                  unused_ok;

  always_comb begin
    aw_hs = s_axi.S_AXI_AWVALID && awready_q;
    w_hs  = s_axi.S_AXI_WVALID && wready_q;
    b_hs  = bvalid_q && s_axi.S_AXI_BREADY;
    ar_hs = s_axi.S_AXI_ARVALID && arready_q;
    r_hs  = rvalid_q && s_axi.S_AXI_RREADY;

    aw_off = (s_axi.S_AXI_AWADDR - BASE_A) >> SH;
    ar_off = (s_axi.S_AXI_ARADDR - BASE_A) >> SH;
    aw_ok  = (s_axi.S_AXI_AWADDR >= BASE_A) && (aw_off < DEPTH_A);
    ar_ok  = (s_axi.S_AXI_ARADDR >= BASE_A) && (ar_off < DEPTH_A);

    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    aw_ok_d   = aw_ok_q;
    if (b_hs) begin
      aw_full_d = 1'b0;
    end else if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_idx_d  = aw_off[IDX_W-1:0];
      aw_ok_d   = aw_ok;
    end

    w_full_d = w_full_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    if (b_hs) begin
      w_full_d = 1'b0;
    end else if (w_hs) begin
      w_full_d = 1'b1;
      wdata_d  = s_axi.S_AXI_WDATA;
      wstrb_d  = s_axi.S_AXI_WSTRB;
    end

    // Delay count starts on the edge where the second of AW/W lands
    wload  = aw_full_d && w_full_d && !(aw_full_q && w_full_q);
    commit = aw_full_q && w_full_q && !bvalid_q && wdone;

    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = aw_ok_q ? OKAY : DECERR;
    end else if (b_hs) begin
      bvalid_d = 1'b0;
    end

    // Gated on both old and new flag so READY returns one edge after the B handshake
    awready_d = !aw_full_d && !aw_full_q;
    wready_d  = !w_full_d && !w_full_q;

    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    case (rstate_q)
      R_IDLE: if (ar_hs) begin
        rstate_d = R_WAIT;
        rdata_d  = ar_ok ? mem_q[ar_off[IDX_W-1:0]] : '0;
        rresp_d  = ar_ok ? OKAY : DECERR;
      end
      R_WAIT: if (rdone) rstate_d = R_RESP;
      R_RESP: if (r_hs) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
    rload     = ar_hs;
    rvalid_d  = (rstate_d == R_RESP);
    arready_d = (rstate_d == R_IDLE) && (rstate_q == R_IDLE);
  end

`ifdef AXI_SLV_RESP_DELAY_EN
  axi_lite_resp_delay u_b_delay (
    .clk     (ACLK),
    .rst_n   (ARESETn),
    .load_i  (wload),
    .value_i (8'(RESP_DELAY)),
    .done_o  (wdone)
  );

  axi_lite_resp_delay u_r_delay (
    .clk     (ACLK),
    .rst_n   (ARESETn),
    .load_i  (rload),
    .value_i (8'(RESP_DELAY)),
    .done_o  (rdone)
  );

  assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, s_axi.S_AXI_WLAST,
                       aw_off, ar_off};
`else
  assign wdone = 1'b1;
  assign rdone = 1'b1;
  assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, s_axi.S_AXI_WLAST,
                       aw_off, ar_off, wload, rload, 8'(RESP_DELAY)};
`endif

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_full_q <= 1'b0;
      aw_ok_q   <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
    end else begin
      aw_full_q <= aw_full_d;
      aw_ok_q   <= aw_ok_d;
      aw_idx_q  <= aw_idx_d;
      w_full_q  <= w_full_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  always_ff @(posedge ACLK) begin
    if (commit && aw_ok_q) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (wstrb_q[b]) mem_q[aw_idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign s_axi.S_AXI_RLAST   = rvalid_q;

endmodule
